// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state type, default timing constants and widths for the PLL sequencer
package pll_ctrl_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT} pll_state_t;
  localparam int DEF_RST_CYCLES = 50;
  localparam int DEF_LOCK_TIMEOUT = 500000;
  localparam int DEF_STABLE_CYCLES = 5000;
  localparam int DEF_MAX_RETRIES = 3;
  localparam int LOST_W = 8;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk)
    if (rst) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_ctrl.sv
// pll_ctrl: ECP5 PLL reset/lock sequencer; PLL_CTRL_STATUS_EN enables the status count ports
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES = DEF_MAX_RETRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              relock,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic              fault,
  output logic [LOST_W-1:0] lock_lost_cnt,
  output logic [3:0]        retry_cnt
);
  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LD = CW'(STABLE_CYCLES - 1);
  pll_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] retry, retry_nx;
  logic locked_s, sync_clr, zero;
  // a lock indication left over from before the PLL reset is discarded
  assign sync_clr = rst || state == PLL_RST;
  assign zero = cnt == '0;
  assign retry_nx = retry + 4'd1;
  sync_2ff #(.RST_VAL(1'b0)) u_sync (.clk(clk), .rst(sync_clr), .d(locked), .q(locked_s));
  // sequencer state, shared down-counter, retry tally and state-decoded outputs
  always_ff @(posedge clk)
    if (rst) begin
      state <= PLL_RST;
      cnt <= RST_LD;
      retry <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      pll_rst <= state == PLL_RST;
      sys_rst <= state != RUN;
      ready <= state == RUN;
      fault <= state == FAULT;
      if (relock && state != PLL_RST) begin
        state <= PLL_RST;
        cnt <= RST_LD;
        retry <= '0;
      end else
        case (state)
          PLL_RST:
            if (zero) begin
              state <= WAIT_LOCK;
              cnt <= TO_LD;
            end else cnt <= cnt - 1'b1;
          WAIT_LOCK:
            if (locked_s) begin
              state <= STABLE;
              cnt <= ST_LD;
            end else if (zero) begin
              retry <= retry_nx;
              state <= (retry_nx == 4'(MAX_RETRIES)) ? FAULT : PLL_RST;
              cnt <= RST_LD;
            end else cnt <= cnt - 1'b1;
          STABLE:
            if (!locked_s) begin
              state <= WAIT_LOCK;
              cnt <= TO_LD;
            end else if (zero) begin
              state <= RUN;
              retry <= '0;
            end else cnt <= cnt - 1'b1;
          RUN:
            if (!locked_s) begin
              state <= PLL_RST;
              cnt <= RST_LD;
            end
          default: ;
        endcase
    end
`ifdef PLL_CTRL_STATUS_EN
  logic [LOST_W-1:0] lost;
  // saturating tally of lock drops observed while running
  always_ff @(posedge clk)
    if (rst) lost <= '0;
    else if (state == RUN && !locked_s && lost != '1) lost <= lost + 1'b1;
  assign lock_lost_cnt = lost;
  assign retry_cnt = retry;
`else
  assign lock_lost_cnt = '0;
  assign retry_cnt = '0;
`endif
endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed self-checking bench for pll_ctrl
module tb_pll_ctrl;
  logic clk = 1'b0, rst = 1'b1, locked = 1'b0, relock = 1'b0;
  logic pll_rst, sys_rst, ready, fault;
  logic [7:0] lock_lost_cnt;
  logic [3:0] retry_cnt;
  int checks = 0, errors = 0, cyc = 0, base = 0;
`ifdef PLL_CTRL_STATUS_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif
  always #5 clk = ~clk;
  pll_ctrl #(.RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)) dut (
    .clk(clk), .rst(rst), .locked(locked), .relock(relock), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .ready(ready), .fault(fault), .lock_lost_cnt(lock_lost_cnt), .retry_cnt(retry_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask
  task automatic do_reset(input logic lk);
    rst = 1'b1;
    locked = lk;
    relock = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cyc = -1;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(ready), 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    locked = 1'b1;
    repeat (3) tick();
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_sys_rst", 32'(sys_rst), 1);
    check("rst_ready", 32'(ready), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_lost", 32'(lock_lost_cnt), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    rst = 1'b0;
    cyc = -1;
    tick();
    check("clean_prst_c0", 32'(pll_rst), 1);
    run_to(3);
    check("clean_prst_c3", 32'(pll_rst), 1);
    run_to(4);
    check("clean_prst_c4", 32'(pll_rst), 0);
    check("clean_sys_c4", 32'(sys_rst), 1);
    run_to(14);
    check("clean_ready_c14", 32'(ready), 0);
    run_to(15);
    check("clean_ready_c15", 32'(ready), 1);
    check("clean_sys_c15", 32'(sys_rst), 0);
    do_reset(1'b1);
    run_to(10);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    run_to(22);
    check("glitch_ready_c22", 32'(ready), 0);
    check("glitch_sys_c22", 32'(sys_rst), 1);
    run_to(23);
    check("glitch_ready_c23", 32'(ready), 1);
    check("glitch_retry", 32'(retry_cnt), 0);
    do_reset(1'b1);
    run_to(15);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    check("dual_lost", 32'(lock_lost_cnt), 32'(EN));
    check("dual_ready_t2", 32'(ready), 1);
    tick();
    check("dual_ready_t3", 32'(ready), 0);
    check("dual_prst_t3", 32'(pll_rst), 1);
    for (int i = 0; i < 300; i++) begin
      wait_ready("loss_reready");
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      tick();
      check("loss_ready_t2", 32'(ready), 1);
      tick();
      check("loss_ready_t3", 32'(ready), 0);
      check("loss_sys_t3", 32'(sys_rst), 1);
      check("loss_prst_t3", 32'(pll_rst), 1);
      if (i == 99) check("loss_lost_101", 32'(lock_lost_cnt), 32'(EN * 101));
    end
    base = cyc - 3;
    run_to(base + 11);
    check("loss_lost_sat", 32'(lock_lost_cnt), 32'(EN * 255));
    check("stable_prst", 32'(pll_rst), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_prst", 32'(pll_rst), 1);
    check("midrst_sys", 32'(sys_rst), 1);
    check("midrst_lost", 32'(lock_lost_cnt), 0);
    check("midrst_retry", 32'(retry_cnt), 0);
    do_reset(1'b0);
    run_to(23);
    check("to_prst_c23", 32'(pll_rst), 0);
    run_to(24);
    check("to_prst_c24", 32'(pll_rst), 1);
    check("to_retry_c24", 32'(retry_cnt), 32'(EN));
    run_to(27);
    check("to_prst_c27", 32'(pll_rst), 1);
    run_to(28);
    check("to_prst_c28", 32'(pll_rst), 0);
    run_to(47);
    check("to_fault_c47", 32'(fault), 0);
    run_to(48);
    check("to_fault_c48", 32'(fault), 1);
    check("to_sys_c48", 32'(sys_rst), 1);
    check("to_prst_c48", 32'(pll_rst), 0);
    check("to_retry_c48", 32'(retry_cnt), 32'(EN * 2));
    run_to(50);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    check("fault_hold_c51", 32'(fault), 1);
    tick();
    check("relock_prst_c52", 32'(pll_rst), 1);
    check("relock_fault_c52", 32'(fault), 0);
    check("relock_retry_c52", 32'(retry_cnt), 0);
    run_to(55);
    check("relock_prst_c55", 32'(pll_rst), 1);
    run_to(56);
    check("relock_prst_c56", 32'(pll_rst), 0);
    do_reset(1'b0);
    run_to(46);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    tick();
    check("edge_prst_c48", 32'(pll_rst), 1);
    check("edge_fault_c48", 32'(fault), 0);
    check("edge_retry_c48", 32'(retry_cnt), 0);
    run_to(60);
    check("edge_fault_c60", 32'(fault), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

Sequencer for the ECP5 PLL. Runs on the free-running 50 MHz board clock and drives the PLL reset, then waits for `locked` and holds off system reset until lock has been continuously stable. It re-sequences the PLL on lock loss, on lock timeout, or on request, and gives up into a fault state after a bounded number of retries.

## Interface
- `RST_CYCLES`, 50: width of the PLL reset pulse in `clk` cycles (1 µs).
- `LOCK_TIMEOUT`, 500000: cycles to wait for lock before a retry (10 ms).
- `STABLE_CYCLES`, 5000: cycles lock must hold continuously before system reset is released (100 µs).
- `MAX_RETRIES`, 3: consecutive lock timeouts tolerated before FAULT; range 1..15.
- `clk` in 1: 50 MHz reference clock, same net as the PLL `clkin`.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock; asynchronous to `clk`.
- `relock` in 1: single-cycle request to re-sequence the PLL.
- `pll_rst` out 1: PLL RST input.
- `sys_rst` out 1: active-high system reset; consumers resynchronise it into `clkout0`.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `lock_lost_cnt` out 8: saturating count of lock losses seen in RUN.
- `retry_cnt` out 4: consecutive timeouts in the current sequence.

## Operation
- `locked` passes through a 2-flop synchroniser, reset value 0, giving `locked_s`.
- One down-counter. Its width is `$clog2` of the largest of the three cycle parameters, plus 1.
- States and behaviour:
  - PLL_RST: `pll_rst`=1. After RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - If `locked_s`=1, go to STABLE with the counter reloaded.
    - If LOCK_TIMEOUT cycles expire, increment `retry_cnt`. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
  - STABLE:
    - If `locked_s`=0, go to WAIT_LOCK with the counter reloaded; `retry_cnt` is unchanged.
    - After STABLE_CYCLES consecutive cycles with lock, go to RUN and clear `retry_cnt`.
  - RUN: `sys_rst`=0, `ready`=1. If `locked_s`=0, increment `lock_lost_cnt` (saturates at 255) and go to PLL_RST.
  - FAULT: `pll_rst`=0, `sys_rst`=1, `fault`=1. Leaves only via `rst` or `relock`.
- `relock`=1 in any state other than PLL_RST: go to PLL_RST and clear `retry_cnt`. `relock` during PLL_RST is ignored.
- `sys_rst`=1 in every state except RUN.
- Simultaneous events:
  - `relock` and a lock drop in the same RUN cycle: the lock drop also counts, so `lock_lost_cnt` is incremented.
  - `relock` and a timeout expiry in the same cycle: `relock` wins; no FAULT, `retry_cnt` cleared.
- `rst` mid-operation: immediate return to PLL_RST on the next edge. `lock_lost_cnt` and `retry_cnt` clear to 0.

## Timing
- Reset values: state PLL_RST, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, counts 0.
- All outputs are registered and decoded from the state register, so they change one edge after the state transition.
- `pll_rst` stays high for exactly RST_CYCLES cycles after `rst` deasserts.
- `locked` to `locked_s`: 2 cycles.
- With lock present at the moment WAIT_LOCK is entered: `ready` rises RST_CYCLES + 2 + STABLE_CYCLES + 1 cycles after `rst` falls.
- Lock loss in RUN: `locked` falls at cycle t → `ready`=0, `sys_rst`=1, `pll_rst`=1 at t+3.

## Configuration
- `PLL_CTRL_STATUS_EN` defined: `lock_lost_cnt` and `retry_cnt` are live as described.
- Undefined: both ports are tied to 0 and their registers are not built.
- The state machine and retry limit are identical either way, because the internal retry counter is always present.

## Structure
- Package `pll_ctrl_pkg` holds:
  - enum `pll_state_t` {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT};
  - the default parameter constants;
  - the `lock_lost_cnt` width.
- Sub-module `sync_2ff` (parameterised reset value) implements the `locked` synchroniser; it is reusable elsewhere.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.

- Clean start: `rst` falls at cycle 0, `locked` high throughout → `pll_rst` high for cycles 0–3; `ready`=1, `sys_rst`=0 at cycle 15.
- Glitchy lock: `locked` drops for 1 cycle 5 cycles into STABLE → return to WAIT_LOCK; `ready` is delayed by the full STABLE_CYCLES counted from relock; `retry_cnt`=0.
- Timeout to fault: `locked` held low → 2 PLL reset pulses, then FAULT with `fault`=1, `sys_rst`=1, `pll_rst`=0 and `retry_cnt`=2 (macro on). `relock` then produces a new 4-cycle `pll_rst` pulse.
- Lock loss in RUN, repeated 300 times → `lock_lost_cnt` saturates at 255; each loss gives `ready`=0 exactly 3 cycles after the `locked` fall.
- `relock` coinciding with a WAIT_LOCK timeout at the MAX_RETRIES boundary → PLL_RST, never FAULT, `retry_cnt`=0.
- `rst` asserted during STABLE → next edge: `pll_rst`=1, `sys_rst`=1, counts 0; build with the macro undefined → both count ports read 0.
